// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam int CBNZ_BIT     = 24;
  localparam int BRANCH_SHIFT = 2;

  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic reg_write_en;
  } strobe_t;

endpackage

// File: rtl/next_pc_m.sv
// Branch resolution and next-PC computation for B/CBZ/CBNZ and sequential flow.
module next_pc_m
  import cpu_seq_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         immediate,
  input  logic                Uncondbranch,
  input  logic                Branch,
  input  logic                zeroflag,
  input  logic                cbnz,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                taken
);

  localparam int OW = (PC_WIDTH > 32) ? PC_WIDTH : 32;

  logic signed [OW-1:0]  imm_ext;
  logic [PC_WIDTH-1:0]   offset;

  // Word offset sign-extended before scaling so negative branches wrap correctly.
  assign imm_ext = OW'($signed(immediate));
  assign offset  = PC_WIDTH'(imm_ext <<< BRANCH_SHIFT);
  assign taken   = Uncondbranch | (Branch & (cbnz ? ~zeroflag : zeroflag));
  assign next_pc = taken ? pc + offset : pc + PC_WIDTH'(4);

endmodule

// File: rtl/cpu_sequencer_m.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer: owns pc, ir and retire count.
module cpu_sequencer_m
  import cpu_seq_pkg::*;
#(
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                Uncondbranch,
  input  logic                Branch,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                RegWrite,
  input  logic [31:0]         immediate,
  input  logic                zeroflag,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                reg_write_en,
  input  logic                halt_req,
  output logic                halted,
  output logic [31:0]         instr_count
);

  state_e              state, state_nx;
  strobe_t             strb;
  logic                retire;
  logic [PC_WIDTH-1:0] npc_c, npc_q;
  logic                taken_unused;

  next_pc_m #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc          (pc),
    .immediate   (immediate),
    .Uncondbranch(Uncondbranch),
    .Branch      (Branch),
    .zeroflag    (zeroflag),
    .cbnz        (ir[CBNZ_BIT]),
    .next_pc     (npc_c),
    .taken       (taken_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_count <= '0;
      npc_q       <= RESET_PC;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_EXECUTE) npc_q <= npc_c;
      if (retire) begin
        pc          <= (state == S_EXECUTE) ? npc_c : npc_q;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    strb     = '0;
    case (state)
      S_FETCH: begin
        strb.imem_req = 1'b1;
        if (imem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXECUTE;
      S_EXECUTE: begin
        if (MemRead || MemWrite) state_nx = S_MEMORY;
        else if (RegWrite)       state_nx = S_WRITEBACK;
        else                     retire   = 1'b1;
      end
      S_MEMORY: begin
        // MemRead and MemWrite together behave as a store.
        strb.dmem_req = 1'b1;
        strb.dmem_we  = MemWrite;
        if (dmem_ack) begin
          if (MemWrite) retire   = 1'b1;
          else          state_nx = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        strb.reg_write_en = 1'b1;
        retire            = 1'b1;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
    if (retire) state_nx = halt_req ? S_HALT : S_FETCH;
  end

  // Reset parks the FSM in FETCH, so the fetch request must be masked while reset is held.
  assign imem_req     = strb.imem_req & reset_n;
  assign dmem_req     = strb.dmem_req;
  assign dmem_we      = strb.dmem_we;
  assign reg_write_en = strb.reg_write_en;
  assign halted       = (state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer_m.sv
// Table-driven bench for cpu_sequencer_m with a retire scoreboard and reset/halt sequences.
module tb_cpu_sequencer_m;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir, pc, immediate = '0, instr_count;
  logic        Uncondbranch = 0, Branch = 0, MemRead = 0, MemWrite = 0, RegWrite = 0;
  logic        zeroflag = 0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        reg_write_en, halt_req = 1'b0, halted;

  cpu_sequencer_m #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc),
    .Uncondbranch(Uncondbranch), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .immediate(immediate), .zeroflag(zeroflag),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_write_en(reg_write_en),
    .halt_req(halt_req), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // ctl = {Uncondbranch, Branch, MemRead, MemWrite, RegWrite}
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ctl;
    logic [31:0] imm;
    logic        zf;
    int          iw;
    int          dw;
    bit          noise;
    bit          halt;
    logic [31:0] exp_pc;
    int          exp_cyc;
    int          exp_wb;
    int          exp_dm;
  } vec_t;

  vec_t tbl[15];
  vec_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Entered at a negedge in the instruction's first FETCH cycle; returns at the
  // negedge of the following instruction's first cycle.
  task automatic run_instr(input vec_t v);
    logic [31:0] c0;
    int cyc = 0, wb = 0, dm = 0, we = 0, viol = 0, iw, dw;
    vec_t e;
    exp_q.push_back(v);
    {Uncondbranch, Branch, MemRead, MemWrite, RegWrite} = v.ctl;
    immediate = v.imm;
    zeroflag  = v.zf;
    iw = v.iw;
    dw = v.dw;
    c0 = instr_count;
    for (int k = 0; k < 60; k++) begin
      if (instr_count != c0) break;
      cyc++;
      if (v.halt && cyc == 2) halt_req = 1'b1;
      if (reg_write_en) wb++;
      if (dmem_req) dm++;
      if (dmem_req && dmem_we) we++;
      if (int'(imem_req) + int'(dmem_req) + int'(reg_write_en) > 1) viol++;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (imem_req) begin
        if (iw == 0) begin imem_ack = 1'b1; imem_rdata = v.instr; end
        else iw--;
      end else if (v.noise) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      end
      if (dmem_req) begin
        if (dw == 0) dmem_ack = 1'b1;
        else dw--;
      end else if (v.noise) dmem_ack = 1'b1;
      @(negedge clk);
    end
    halt_req = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    e = exp_q.pop_front();
    chk("retire_count", instr_count, c0 + 32'd1);
    chk("cycles",       cyc,         e.exp_cyc);
    chk("reg_write_en", wb,          e.exp_wb);
    chk("dmem_req",     dm,          e.exp_dm);
    chk("dmem_we",      we,          e.ctl[1] ? e.exp_dm : 0);
    chk("onehot",       viol,        0);
    chk("pc",           pc,          e.exp_pc);
    chk("ir",           ir,          e.instr);
    chk("halted",       {31'd0, halted}, {31'd0, e.halt});
  endtask

  initial begin
    tbl[0]  = '{32'h91002021, 5'b00001, 32'd8,        1'b0, 0, 0, 1'b0, 1'b0, 32'h04, 4, 1, 0};
    tbl[1]  = '{32'hF8000041, 5'b00010, 32'd0,        1'b0, 0, 2, 1'b0, 1'b0, 32'h08, 6, 0, 3};
    tbl[2]  = '{32'hB40000E3, 5'b01000, 32'd7,        1'b0, 0, 0, 1'b0, 1'b0, 32'h0C, 3, 0, 0};
    tbl[3]  = '{32'h17FFFFFF, 5'b10000, 32'hFFFFFFFF, 1'b0, 1, 0, 1'b0, 1'b0, 32'h08, 4, 0, 0};
    tbl[4]  = '{32'hB40000E3, 5'b01000, 32'd7,        1'b1, 0, 0, 1'b0, 1'b0, 32'h24, 3, 0, 0};
    tbl[5]  = '{32'h14000007, 5'b10000, 32'd7,        1'b0, 0, 0, 1'b0, 1'b0, 32'h40, 3, 0, 0};
    tbl[6]  = '{32'h17FFFFFA, 5'b10000, 32'hFFFFFFFA, 1'b1, 0, 0, 1'b1, 1'b0, 32'h28, 3, 0, 0};
    tbl[7]  = '{32'hF8400043, 5'b00101, 32'd0,        1'b0, 0, 1, 1'b0, 1'b0, 32'h2C, 6, 1, 2};
    tbl[8]  = '{32'h17FFFFF7, 5'b10000, 32'hFFFFFFF7, 1'b0, 0, 0, 1'b0, 1'b0, 32'h08, 3, 0, 0};
    tbl[9]  = '{32'hB5000003, 5'b01000, 32'd0,        1'b0, 0, 0, 1'b0, 1'b0, 32'h08, 3, 0, 0};
    tbl[10] = '{32'hB5000023, 5'b01000, 32'd1,        1'b1, 0, 0, 1'b0, 1'b0, 32'h0C, 3, 0, 0};
    tbl[11] = '{32'hF8000041, 5'b00110, 32'd0,        1'b0, 0, 0, 1'b0, 1'b0, 32'h10, 4, 0, 1};
    tbl[12] = '{32'h8B020020, 5'b00001, 32'd0,        1'b0, 2, 0, 1'b1, 1'b0, 32'h14, 6, 1, 0};
    tbl[13] = '{32'hD503201F, 5'b00000, 32'd5,        1'b1, 0, 0, 1'b0, 1'b0, 32'h18, 3, 0, 0};
    tbl[14] = '{32'h91002021, 5'b00001, 32'd8,        1'b0, 0, 0, 1'b0, 1'b1, 32'h1C, 4, 1, 0};

    // Reset state while reset is held.
    #12;
    chk("rst_pc",       pc,          32'h0);
    chk("rst_ir",       ir,          32'h0);
    chk("rst_count",    instr_count, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_strobes",  {29'd0, dmem_req, dmem_we, reg_write_en}, 32'd0);
    chk("rst_halted",   {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_imem_req", {31'd0, imem_req}, 32'd1);

    foreach (tbl[i]) run_instr(tbl[i]);

    // HALT is sticky and fetches nothing.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
      chk("halt_sticky",   {31'd0, halted},   32'd1);
    end
    chk("halt_count", instr_count, 32'd15);

    // Reset leaves HALT.
    #1 reset_n = 1'b0;
    #1;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_pc",     pc,              32'h0);
    chk("rst2_count",  instr_count,     32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst2_imem_req", {31'd0, imem_req}, 32'd1);
    run_instr(tbl[0]);

    // LDR interrupted by reset while waiting in MEMORY.
    {Uncondbranch, Branch, MemRead, MemWrite, RegWrite} = 5'b00101;
    immediate = '0;
    for (int k = 0; k < 10; k++) begin
      if (dmem_req) break;
      imem_ack   = imem_req;
      imem_rdata = 32'hF8400043;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("ldr_in_memory", {31'd0, dmem_req}, 32'd1);
    chk("ldr_ir",        ir,                32'hF8400043);
    #2 reset_n = 1'b0;
    #1;
    chk("ldr_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("ldr_rst_pc",       pc,                32'h0);
    chk("ldr_rst_count",    instr_count,       32'h0);
    chk("ldr_rst_ir",       ir,                32'h0);
    chk("ldr_rst_imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ldr_restart_imem_req", {31'd0, imem_req}, 32'd1);
    run_instr(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer_m.md
# cpu_sequencer_m

Multi-cycle control sequencer for the LEGv8 datapath (decoder_m, registers_m, ALU_m, ALUControl_m, dataMemory_m, multiplexer_m). It owns the program counter and the instruction register, fetches over a req/ack handshake, and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It converts the decoder's level control signals into single-cycle enables and strobes, resolves B/CBZ/CBNZ, and counts retired instructions.

## Interface
- PC_WIDTH, 32, program counter width
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- imem_req  output  1  instruction fetch request at address pc
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- ir  output  32  instruction register, drives decoder_m/ALUControl_m
- pc  output  PC_WIDTH  current instruction address
- Uncondbranch, Branch, MemRead, MemWrite, RegWrite  input  1 each  decoder_m controls, decoded from ir
- immediate  input  32  signed decoder_m immediate (word offset for branches)
- zeroflag  input  1  ALU_m zero flag
- dmem_req  output  1  data memory access request
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high
- dmem_ack  input  1  data access complete
- reg_write_en  output  1  one-cycle register file write strobe
- halt_req  input  1  stop at the next instruction boundary
- halted  output  1  sequencer parked in HALT
- instr_count  output  32  retired instruction count, wraps at 2^32

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: imem_req=1. On the cycle imem_ack=1, ir<=imem_rdata and go to DECODE. imem_req is held until ack.
- DECODE: one cycle so the decoder and register reads settle. No strobes.
- EXECUTE: one cycle. Resolve taken = Uncondbranch | (Branch & (ir[24] ? ~zeroflag : zeroflag)); ir[24]=1 is CBNZ. Latch next_pc = taken ? pc + (immediate<<<2) : pc + 4, truncated to PC_WIDTH and wrapping mod 2^PC_WIDTH.
  - MemRead or MemWrite: go to MEMORY.
  - Else RegWrite: go to WRITEBACK.
  - Else: retire.
- MEMORY: dmem_req=1 and dmem_we=MemWrite, held until dmem_ack. On ack:
  - Load: go to WRITEBACK.
  - Store: retire.
- WRITEBACK: reg_write_en=1 for exactly this cycle, then retire.
- Retire is one edge with three actions: pc<=next_pc, instr_count increments, and the next state is halt_req ? HALT : FETCH.
- HALT: all strobes 0. Sticky until reset. halted=1.
- halt_req is ignored everywhere except at retire. An in-flight instruction always completes.
- MemRead and MemWrite both high is illegal; the block treats it as a store.
- At most one of imem_req, dmem_req, reg_write_en is high in any cycle.

## Timing
- Reset (asynchronous, immediate on reset_n=0) forces all outputs to their reset values:
  - pc=RESET_PC, ir=0, instr_count=0
  - imem_req=dmem_req=dmem_we=reg_write_en=0, halted=0
  - state=FETCH
- An outstanding request is dropped on reset with no completion. imem_req rises in the first cycle after reset_n deasserts.
- imem_ack/dmem_ack may assert in the same cycle as the request (zero-wait memory). Each wait cycle adds one cycle. An ack while the matching req is low is ignored.
- Cycle counts with zero-wait memory:
  - Branch or non-writing instruction: 3 cycles.
  - ALU or ADDI: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- pc changes only on the retire edge. ir changes only on the FETCH ack edge. Both are stable from DECODE through retire.
- instr_count wraps from 0xFFFFFFFF to 0 without a flag.

## Structure
- Shared package cpu_seq_pkg holds:
  - state enum (3-bit encoding)
  - CBNZ_BIT=24
  - BRANCH_SHIFT=2
- Sub-module next_pc_m (combinational): inputs pc, immediate, Uncondbranch, Branch, zeroflag, ir[24]; outputs next_pc and taken. Testable standalone.
- FSM, pc/ir/instr_count registers and strobe decode stay in cpu_sequencer_m.

## Test plan
- ADDI 'h91002021 at pc=0, zero-wait: 4-cycle instruction, reg_write_en high only in cycle 4, then pc=4, instr_count=1.
- STR 'hF8000041, dmem_ack delayed 2 cycles: dmem_req and dmem_we held 3 cycles, reg_write_en never asserts, retire gives pc+4.
- CBZ 'hB40000E3 at pc=8: with zeroflag=1, pc becomes 36; with zeroflag=0, pc becomes 12. CBNZ 'hB5000003 with zeroflag=0 at pc=8 gives pc=8+(imm<<2).
- B 'h17FFFFFA at pc=0x40: next pc=0x28, 3 cycles, no reg_write_en/dmem_req.
- LDR 'hF8400043 with reset_n pulsed low during MEMORY: dmem_req drops immediately, pc=0, instr_count=0, FETCH restarts with imem_req=1.
- halt_req raised during DECODE of an ADDI: the instruction completes (reg_write_en pulse, pc+4), then halted=1 and imem_req stays 0 until reset.
